// File: rtl/alu32_flags.sv
// Registered 32-bit ALU with NZCV flags for the MiniMicro datapath.
// Optional multiplier on opcode 12 is enabled by defining ALU_MUL_EN.
module alu32_flags #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       instruction,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam logic [4:0] OP_ANDS = 5'd1,  OP_ORRS = 5'd2,  OP_MVNS = 5'd3,
                          OP_EORS = 5'd4,  OP_LSLS = 5'd5,  OP_LSRS = 5'd6,
                          OP_ADDS = 5'd7,  OP_SUBS = 5'd8,  OP_CMP  = 5'd9,
                          OP_ASRS = 5'd10, OP_RORS = 5'd11, OP_MULS = 5'd12,
                          OP_BICS = 5'd13, OP_MOVS = 5'd14, OP_CMN  = 5'd15;

   logic [4:0]       sh;
   logic [WIDTH:0]   lsl, lsr, asr, add, sub;
   logic [WIDTH-1:0] ror, val;
   logic             upd, wr_res, c_nxt, v_nxt;

   assign sh = num2[4:0];

   // Right shifts carry one guard bit below the LSB so bit 0 is the last bit shifted out.
   always_comb begin
      lsl = {1'b0, num1} << sh;
      lsr = {num1, 1'b0} >> sh;
      asr = $signed({num1, 1'b0}) >>> sh;
      ror = (num1 >> sh) | (num1 << (6'd32 - {1'b0, sh}));
      add = {1'b0, num1} + {1'b0, num2};
      sub = {1'b0, num1} + {1'b0, ~num2} + (WIDTH+1)'(1);
   end

   always_comb begin
      val    = '0;
      upd    = 1'b1;
      wr_res = 1'b1;
      c_nxt  = flags[1];
      v_nxt  = flags[0];
      case (instruction)
         OP_ANDS: val = num1 & num2;
         OP_ORRS: val = num1 | num2;
         OP_MVNS: val = ~num1;
         OP_EORS: val = num1 ^ num2;
         OP_BICS: val = num1 & ~num2;
         OP_MOVS: val = num2;
         OP_LSLS: begin
            val = lsl[WIDTH-1:0];
            if (sh != 5'd0) c_nxt = lsl[WIDTH];
         end
         OP_LSRS: begin
            val = lsr[WIDTH:1];
            if (sh != 5'd0) c_nxt = lsr[0];
         end
         OP_ASRS: begin
            val = asr[WIDTH:1];
            if (sh != 5'd0) c_nxt = asr[0];
         end
         OP_RORS: begin
            val = ror;
            if (sh != 5'd0) c_nxt = ror[WIDTH-1];
         end
         OP_ADDS, OP_CMN: begin
            val    = add[WIDTH-1:0];
            c_nxt  = add[WIDTH];
            v_nxt  = (num1[WIDTH-1] == num2[WIDTH-1]) && (add[WIDTH-1] != num1[WIDTH-1]);
            wr_res = (instruction == OP_ADDS);
         end
         OP_SUBS, OP_CMP: begin
            val    = sub[WIDTH-1:0];
            c_nxt  = sub[WIDTH];
            v_nxt  = (num1[WIDTH-1] != num2[WIDTH-1]) && (sub[WIDTH-1] != num1[WIDTH-1]);
            wr_res = (instruction == OP_SUBS);
         end
`ifdef ALU_MUL_EN
         OP_MULS: val = num1 * num2;
`endif
         default: begin
            upd    = 1'b0;
            wr_res = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         flags  <= 4'b0000;
      end else begin
         if (wr_res) result <= val;
         if (upd)    flags  <= {val[WIDTH-1], val == '0, c_nxt, v_nxt};
      end
   end

endmodule

// File: tb/tb_alu32_flags.sv
// Self-checking bench for alu32_flags: directed cases plus random ops against a reference model.
module tb_alu32_flags;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  instruction = 5'd0;
   logic [31:0] num1 = 32'd0, num2 = 32'd0;
   logic [31:0] result;
   logic [3:0]  flags;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_res = 32'd0;
   logic [3:0]  exp_flg = 4'd0;

   alu32_flags #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .instruction(instruction),
      .num1(num1), .num2(num2), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   // Reference: arithmetic on wide integers, returns {result, N, Z, C, V}.
   function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a, b,
                                         input logic [31:0] pr, input logic [3:0] pf);
      logic [31:0] val;
      logic [63:0] dbl;
      logic        c, v, upd, wr;
      longint      u, s;
      int          sh;
      sh = int'(b[4:0]);
      c = pf[1]; v = pf[0]; upd = 1'b1; wr = 1'b1; val = 32'd0;
      case (op)
         5'd1:  val = a & b;
         5'd2:  val = a | b;
         5'd3:  val = ~a;
         5'd4:  val = a ^ b;
         5'd13: val = a & ~b;
         5'd14: val = b;
         5'd5: begin val = a << sh; if (sh != 0) c = a[32-sh]; end
         5'd6: begin val = a >> sh; if (sh != 0) c = a[sh-1]; end
         5'd10: begin val = $signed(a) >>> sh; if (sh != 0) c = a[sh-1]; end
         5'd11: begin
            dbl = {a, a} >> sh;
            val = dbl[31:0];
            if (sh != 0) c = val[31];
         end
         5'd7, 5'd15: begin
            u = longint'(a) + longint'(b);
            s = longint'($signed(a)) + longint'($signed(b));
            val = u[31:0];
            c = u[32];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            wr = (op == 5'd7);
         end
         5'd8, 5'd9: begin
            s = longint'($signed(a)) - longint'($signed(b));
            val = a - b;
            c = (a >= b);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            wr = (op == 5'd8);
         end
`ifdef ALU_MUL_EN
         5'd12: begin u = longint'(a) * longint'(b); val = u[31:0]; end
`endif
         default: begin upd = 1'b0; wr = 1'b0; end
      endcase
      model = {wr ? val : pr, upd ? {val[31], val == 32'd0, c, v} : pf};
   endfunction

   task automatic do_op(input logic [4:0] op, input logic [31:0] a, b);
      logic [35:0] m;
      @(negedge clk);
      instruction = op; num1 = a; num2 = b;
      m = model(op, a, b, exp_res, exp_flg);
      @(posedge clk); #1;
      exp_res = m[35:4];
      exp_flg = m[3:0];
   endtask

   task automatic test_reset;
      #2;
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
      checks++; if (flags !== 4'd0) begin errors++; $display("FAIL reset_flags got=%b exp=%b", flags, 4'd0); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_logic;
      do_op(5'd1, 32'd15, 32'd10);
      checks++; if ({result, flags} !== {32'd10, 4'b0000}) begin errors++; $display("FAIL ands got=%h/%b exp=%h/%b", result, flags, 32'd10, 4'b0000); end
      do_op(5'd2, 32'd500, 32'd5);
      checks++; if ({result, flags} !== {32'd501, 4'b0000}) begin errors++; $display("FAIL orrs got=%h/%b exp=%h/%b", result, flags, 32'd501, 4'b0000); end
      do_op(5'd3, 32'hFFFFFFA0, 32'h12345678);
      checks++; if ({result, flags} !== {32'h5F, 4'b0000}) begin errors++; $display("FAIL mvns got=%h/%b exp=%h/%b", result, flags, 32'h5F, 4'b0000); end
      do_op(5'd4, 32'd295, 32'd426);
      checks++; if ({result, flags} !== {32'd141, 4'b0000}) begin errors++; $display("FAIL eors got=%h/%b exp=%h/%b", result, flags, 32'd141, 4'b0000); end
   endtask

   task automatic test_arith;
      do_op(5'd7, 32'd9, 32'd1);
      checks++; if ({result, flags} !== {32'd10, 4'b0000}) begin errors++; $display("FAIL adds_small got=%h/%b exp=%h/%b", result, flags, 32'd10, 4'b0000); end
      do_op(5'd7, 32'h7FFFFFFF, 32'd1);
      checks++; if ({result, flags} !== {32'h80000000, 4'b1001}) begin errors++; $display("FAIL adds_ovf got=%h/%b exp=%h/%b", result, flags, 32'h80000000, 4'b1001); end
      do_op(5'd7, 32'hFFFFFFFF, 32'd1);
      checks++; if ({result, flags} !== {32'd0, 4'b0110}) begin errors++; $display("FAIL adds_carry got=%h/%b exp=%h/%b", result, flags, 32'd0, 4'b0110); end
      do_op(5'd8, 32'd5, 32'd5);
      checks++; if ({result, flags} !== {32'd0, 4'b0110}) begin errors++; $display("FAIL subs_eq got=%h/%b exp=%h/%b", result, flags, 32'd0, 4'b0110); end
      do_op(5'd9, 32'd3, 32'd5);
      checks++; if ({result, flags} !== {32'd0, 4'b1000}) begin errors++; $display("FAIL cmp got=%h/%b exp=%h/%b", result, flags, 32'd0, 4'b1000); end
      do_op(5'd8, 32'h80000000, 32'd1);
      checks++; if ({result, flags} !== {32'h7FFFFFFF, 4'b0011}) begin errors++; $display("FAIL subs_ovf got=%h/%b exp=%h/%b", result, flags, 32'h7FFFFFFF, 4'b0011); end
   endtask

   task automatic test_hold;
      do_op(5'd0, 32'hDEADBEEF, 32'h1);
      checks++; if ({result, flags} !== {32'h7FFFFFFF, 4'b0011}) begin errors++; $display("FAIL nop got=%h/%b exp=%h/%b", result, flags, 32'h7FFFFFFF, 4'b0011); end
      do_op(5'd20, 32'h0, 32'h0);
      checks++; if ({result, flags} !== {32'h7FFFFFFF, 4'b0011}) begin errors++; $display("FAIL op20 got=%h/%b exp=%h/%b", result, flags, 32'h7FFFFFFF, 4'b0011); end
      do_op(5'd15, 32'h1, 32'h2);
      checks++; if ({result, flags} !== {32'h7FFFFFFF, 4'b0000}) begin errors++; $display("FAIL cmn got=%h/%b exp=%h/%b", result, flags, 32'h7FFFFFFF, 4'b0000); end
   endtask

   task automatic test_shift;
      do_op(5'd5, 32'h80000001, 32'd1);
      checks++; if ({result, flags} !== {32'h2, 4'b0010}) begin errors++; $display("FAIL lsls got=%h/%b exp=%h/%b", result, flags, 32'h2, 4'b0010); end
      do_op(5'd10, 32'h80000000, 32'd4);
      checks++; if ({result, flags} !== {32'hF8000000, 4'b1000}) begin errors++; $display("FAIL asrs got=%h/%b exp=%h/%b", result, flags, 32'hF8000000, 4'b1000); end
      do_op(5'd7, 32'hFFFFFFFF, 32'd2);
      do_op(5'd6, 32'h12345678, 32'hFFFFFFE0);
      checks++; if ({result, flags} !== {32'h12345678, 4'b0010}) begin errors++; $display("FAIL lsrs_sh0 got=%h/%b exp=%h/%b", result, flags, 32'h12345678, 4'b0010); end
      do_op(5'd11, 32'h00000001, 32'd1);
      checks++; if ({result, flags} !== {32'h80000000, 4'b1010}) begin errors++; $display("FAIL rors got=%h/%b exp=%h/%b", result, flags, 32'h80000000, 4'b1010); end
   endtask

   task automatic test_mul;
      do_op(5'd12, 32'd6, 32'd7);
`ifdef ALU_MUL_EN
      checks++; if ({result, flags} !== {32'd42, 4'b0010}) begin errors++; $display("FAIL muls got=%h/%b exp=%h/%b", result, flags, 32'd42, 4'b0010); end
`else
      checks++; if ({result, flags} !== {32'h80000000, 4'b1010}) begin errors++; $display("FAIL muls_off got=%h/%b exp=%h/%b", result, flags, 32'h80000000, 4'b1010); end
`endif
   endtask

   task automatic test_async_reset;
      do_op(5'd14, 32'h0, 32'hCAFE0001);
      #2 rst = 1'b1;
      #1;
      checks++; if ({result, flags} !== 36'd0) begin errors++; $display("FAIL async_reset got=%h/%b exp=0/0", result, flags); end
      instruction = 5'd7; num1 = 32'd9; num2 = 32'd1;
      @(posedge clk); #1;
      checks++; if ({result, flags} !== 36'd0) begin errors++; $display("FAIL reset_hold got=%h/%b exp=0/0", result, flags); end
      exp_res = 32'd0; exp_flg = 4'd0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      exp_res = 32'd10;
      checks++; if ({result, flags} !== {32'd10, 4'b0000}) begin errors++; $display("FAIL post_reset got=%h/%b exp=%h/%b", result, flags, 32'd10, 4'b0000); end
   endtask

   task automatic test_random;
      logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h55555555};
      logic [31:0] a, b;
      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         do_op(5'($urandom_range(0, 31)), a, b);
         checks++;
         if ({result, flags} !== {exp_res, exp_flg}) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%b exp=%h/%b", i, instruction, a, b, result, flags, exp_res, exp_flg);
         end
      end
   endtask

   initial begin
      test_reset;
      test_logic;
      test_arith;
      test_hold;
      test_shift;
      test_mul;
      test_async_reset;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
